branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution for the CPU's branch-compare datapath.
- Accepts one branch request at a time over a valid/ready handshake and registers both operands and the branch sense.
- Performs the equality compare in a dedicated stage, then returns taken/not-taken and the redirect PC to fetch over a second valid/ready handshake.
- Also keeps saturating branch and taken-branch statistics counters for performance monitoring.

Parameters:
- DATA_W, 20, compare operand width.
- ADDR_W, 16, PC/target address width.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush; abandons any in-flight branch.
- req_valid  in  1  branch request valid.
- req_ready  out  1  controller can accept a request this cycle.
- req_a  in  DATA_W  compare operand 0.
- req_b  in  DATA_W  compare operand 1.
- req_be_select  in  1  branch sense: 1 = branch-if-equal, 0 = branch-if-not-equal.
- req_target  in  ADDR_W  branch target address.
- req_pc_next  in  ADDR_W  fall-through address.
- res_valid  out  1  resolution result valid.
- res_ready  in  1  consumer accepts the result.
- res_taken  out  1  branch taken.
- res_pc  out  ADDR_W  next PC: req_target if taken, else req_pc_next.
- br_count  out  CNT_W  resolved branches (saturating).
- taken_count  out  CNT_W  resolved taken branches (saturating).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - res_valid, res_taken, res_pc, br_count and taken_count = 0.
  - All operand registers = 0.
  - req_ready = 1 once rst_n is high.
- State machine, encoded states IDLE, CMP, RESP:
  - IDLE: req_ready = 1. A request is accepted when req_valid & req_ready; latch a, b, be_select, target and pc_next, then go to CMP.
  - CMP: req_ready = 0. Compute eq = (a == b) over the full DATA_W width, unsigned bitwise. taken = be_select ? eq : ~eq. Register res_taken and res_pc = taken ? target : pc_next. Set res_valid = 1 and go to RESP.
  - RESP: res_valid = 1. res_taken and res_pc are held stable until res_ready. When res_valid & res_ready:
    - br_count increments by 1 and saturates at all-ones.
    - taken_count increments only if res_taken, and also saturates.
    - If req_valid is also high in the same cycle, the new request is accepted (req_ready = res_ready in RESP) and the next state is CMP (back-to-back path).
    - Otherwise the next state is IDLE and res_valid drops.
- Latency:
  - Accept edge N; res_valid is high after edge N+1. Best-case result availability is the cycle after the compare stage.
  - Sustained throughput is 1 branch per 2 cycles with res_ready held high.
- Flush:
  - When flush is sampled high, the next state is IDLE from any state.
  - res_valid clears on that edge; no counter update occurs even if res_ready was high in the same cycle.
  - req_ready is forced to 0 during the flush cycle, so no request is accepted.
  - Flush takes priority over all handshakes.
- Boundaries:
  - res_ready high while res_valid is low is ignored.
  - req_valid while in CMP is not accepted; the requester must hold the request.
  - Counters at all-ones stay at all-ones; neither counter wraps.
  - An rst_n assertion mid-operation aborts immediately and all outputs return to reset values asynchronously.
  - res_pc and res_taken are don't-care when res_valid = 0, but are registered and change only on a CMP → RESP transition or on reset.

Test Plan:
- Reset then BEQ taken: a = 111, b = 111, be_select = 1, target = 0x0040, pc_next = 0x0011, res_ready = 1 → res_valid two edges after accept, res_taken = 1, res_pc = 0x0040, br_count = 1, taken_count = 1.
- BNE cases:
  - a = 0, b = 5, be_select = 0 → res_taken = 1, res_pc = target.
  - a = 49, b = 49, be_select = 0 → res_taken = 0, res_pc = pc_next.
  - Check taken_count tracks correctly across both.
- Backpressure: res_ready = 0 for 5 cycles with req_valid held → res_valid, res_pc and res_taken stable, req_ready = 0, counters unchanged. Raise res_ready → new request accepted in the same cycle, next result 2 edges later.
- Back-to-back: 4 requests with res_ready = 1 throughout → a result every 2 cycles, br_count = 4. Include a = 0x80000, b = 0x00000 to confirm MSB participates (not equal).
- Flush in CMP, and flush in RESP with res_ready = 1 → state IDLE, res_valid = 0 next cycle, counters unchanged, and a simultaneous req_valid is not accepted.
- Saturation with CNT_W = 4: 17 taken branches → br_count = taken_count = 15. Then assert rst_n = 0 asynchronously mid-CMP → all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// branch_resolve_ctrl: single-request branch compare sequencer (IDLE -> CMP -> RESP)
// with saturating branch / taken-branch statistics counters.
module branch_resolve_ctrl #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_be_select,
  input  logic [ADDR_W-1:0] req_target,
  input  logic [ADDR_W-1:0] req_pc_next,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_pc,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                be_q;
  logic [ADDR_W-1:0]   target_q, pc_next_q;
  logic                res_taken_q;
  logic [ADDR_W-1:0]   res_pc_q;
  logic [CNT_W-1:0]    br_count_q, taken_count_q;

  logic                accept;
  logic                res_fire;
  logic                cmp_eq;
  logic                cmp_taken;

  assign cmp_eq    = (a_q == b_q);
  assign cmp_taken = be_q ? cmp_eq : ~cmp_eq;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    res_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = CMP;
      end
      CMP: state_d = RESP;
      RESP: begin
        req_ready = res_ready;
        if (res_ready) begin
          res_fire = 1'b1;
          state_d  = req_valid ? CMP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides every handshake: nothing is accepted or retired.
    if (flush) begin
      req_ready = 1'b0;
      res_fire  = 1'b0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      be_q          <= 1'b0;
      target_q      <= '0;
      pc_next_q     <= '0;
      res_taken_q   <= 1'b0;
      res_pc_q      <= '0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q       <= req_a;
        b_q       <= req_b;
        be_q      <= req_be_select;
        target_q  <= req_target;
        pc_next_q <= req_pc_next;
      end
      // Result registers move only on a real CMP -> RESP transition.
      if (state_q == CMP && !flush) begin
        res_taken_q <= cmp_taken;
        res_pc_q    <= cmp_taken ? target_q : pc_next_q;
      end
      if (res_fire) begin
        if (br_count_q != CNT_MAX) br_count_q <= br_count_q + CNT_ONE;
        if (res_taken_q && taken_count_q != CNT_MAX)
          taken_count_q <= taken_count_q + CNT_ONE;
      end
    end
  end

  assign res_valid   = (state_q == RESP);
  assign res_taken   = res_taken_q;
  assign res_pc      = res_pc_q;
  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;

endmodule
`default_nettype wire
